// File: rtl/tag_overflow_buffer_if.sv
// Tag overflow buffer bus interface.
// Groups the tagger write side and the consumer read side:
//   in_enable/in_data/in_full        tagger write strobe, tag word, backpressure
//   out_valid/out_data/out_ready     first-word-fall-through read handshake
//   drop_total                       saturating count of dropped tag words
// master: the environment (tagger and consumer); slave: the buffer.
interface tag_overflow_buffer_if;
   logic        in_enable;
   logic [31:0] in_data;
   logic        in_full;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [31:0] drop_total;

   modport master (
      output in_enable, in_data, out_ready,
      input  in_full, out_valid, out_data, drop_total
   );

   modport slave (
      input  in_enable, in_data, out_ready,
      output in_full, out_valid, out_data, drop_total
   );
endinterface

// File: rtl/tag_overflow_buffer.sv
// Tag overflow buffer: a first-word-fall-through FIFO of 2^DEPTH_LOG2 32-bit tag words
// between the tagger and a consumer. Words that arrive while the FIFO is full are
// dropped and counted. After the first drop the buffer enters a loss state in which
// every incoming word is dropped until a slot frees up, so no tag can overtake the
// loss record.
//
// Optional feature: define TAG_OVERFLOW_MARKER_EN to write a loss record
// {16'hFFFF, loss_count} into the FIFO when leaving the loss state. Without it the
// loss state is still left the same way but no FIFO slot is consumed.
//
// Ports:
//   clk   rising-edge clock of the tagger domain
//   rst   synchronous active-high reset (control state only, storage is not cleared)
//   bus   tag_overflow_buffer_if.slave: write strobe/data/full, read valid/data/ready,
//         drop_total
module tag_overflow_buffer #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   tag_overflow_buffer_if.slave        bus
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   typedef enum logic [0:0] {StNormal, StLoss} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [15:0]           loss_q, loss_d;
   logic [31:0]           drop_q, drop_d;
   logic [31:0]           mem_q [Depth];

   logic        full;
   logic        pop;
   logic        we;
   logic        drop;
   logic [31:0] wdata;
   logic [15:0] loss_inc;

   // Full is taken from the registered occupancy only, so a same-cycle pop never
   // opens the door for a push.
   assign full = (count_q == CntW'(Depth));

   always_comb begin
      pop      = (count_q != '0) && bus.out_ready;
      we       = 1'b0;
      drop     = 1'b0;
      wdata    = bus.in_data;
      state_d  = state_q;
      loss_d   = loss_q;
      loss_inc = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;

      unique case (state_q)
         StNormal: begin
            if (bus.in_enable) begin
               if (full) begin
                  drop    = 1'b1;
                  loss_d  = loss_inc;
                  state_d = StLoss;
               end else begin
                  we = 1'b1;
               end
            end
         end
         StLoss: begin
            drop = bus.in_enable;
            if (!full) begin
               // A word arriving in the exit cycle is still dropped and is part of
               // the reported count.
`ifdef TAG_OVERFLOW_MARKER_EN
               we    = 1'b1;
               wdata = {16'hFFFF, (bus.in_enable ? loss_inc : loss_q)};
`endif
               loss_d  = '0;
               state_d = StNormal;
            end else if (bus.in_enable) begin
               loss_d = loss_inc;
            end
         end
         default: state_d = StNormal;
      endcase

      drop_d  = (drop && (drop_q != 32'hFFFF_FFFF)) ? drop_q + 32'd1 : drop_q;
      wptr_d  = we  ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
      count_d = count_q + CntW'(we) - CntW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StNormal;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         loss_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         loss_q  <= loss_d;
         drop_q  <= drop_d;
      end
   end

   // Storage has no reset; only the control state above is cleared.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   assign bus.in_full    = full;
   assign bus.out_valid  = (count_q != '0);
   assign bus.out_data   = mem_q[rptr_q];
   assign bus.drop_total = drop_q;

endmodule
